// File: rtl/point_fifo_wb.sv
// point_fifo_wb
//   Gathers measured waveform points from two channel controllers, tags each
//   with its channel, and queues them in one shared FIFO that software drains
//   over a Wishbone slave port.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wb_dat_i / wb_dat_o       write data / registered read data (32 bits)
//   wb_adr_i                  byte address, only [3:2] decoded
//   wb_we_i, wb_sel_i         write enable, byte lanes (writes only)
//   wb_cyc_i, wb_stb_i        cycle / strobe
//   wb_ack_o                  one-cycle acknowledge, one cycle after request
//   chN_point_rdy_i           one-cycle new-point strobe for channel N
//   chN_point_v_i / _t_i      threshold code / delay code of the point
//   irq_o                     level interrupt, FIFO level >= irq_thr (thr != 0)
//
// Register map (wb_adr_i[3:2])
//   0 DATA   RO  pop FIFO head; reads 0 without popping when empty
//   1 STATUS RO  [8:0] level, [16] empty, [17] full, [18] ovf, [31:24] drop_cnt
//   2 CTRL   RW  [0] enable, [1] clear (write-1, reads 0), [15:8] irq_thr
//   3        reads 0, writes ignored
module point_fifo_wb #(
  parameter int DEPTH_LOG2 = 4,
  parameter int V_WIDTH    = 16,
  parameter int T_WIDTH    = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  input  logic [31:0]        wb_adr_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic               wb_ack_o,
  input  logic               ch1_point_rdy_i,
  input  logic               ch2_point_rdy_i,
  input  logic [V_WIDTH-1:0] ch1_point_v_i,
  input  logic [V_WIDTH-1:0] ch2_point_v_i,
  input  logic [T_WIDTH-1:0] ch1_point_t_i,
  input  logic [T_WIDTH-1:0] ch2_point_t_i,
  output logic               irq_o
);

  localparam int PW = T_WIDTH + V_WIDTH;   // point payload {t, v}
  localparam int EW = PW + 1;              // stored entry {channel, t, v}
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  // FIFO storage; the head is copied into wb_dat_o on the ack edge
  logic [EW-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [1:0]            cap_valid_q, cap_valid_d;
  logic [1:0][PW-1:0]    cap_data_q, cap_data_d;
  logic                  last_ch2_q, last_ch2_d;
  logic                  enable_q, enable_d;
  logic [7:0]            irq_thr_q, irq_thr_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic                  irq_q, irq_d;

  logic                  acc, rd_acc, wr_acc;
  logic [1:0]            reg_sel;
  logic                  full, empty, clear, pop, push, push_ch;
  logic [1:0]            rdy_vec, drain, load, drop;
  logic [1:0][PW-1:0]    pt_vec;
  logic [EW-1:0]         head, push_word;
  logic [8:0]            drop_sum;
  logic [31:0]           status_word, ctrl_word;

  // Bits that are not decoded
  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16],
                         wb_dat_i[7:2], wb_sel_i[3:2]};

  // A new request is accepted only when no ack is outstanding, so a held
  // strobe produces at most one ack (and one pop) every two cycles.
  assign acc     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign rd_acc  = acc & ~wb_we_i;
  assign wr_acc  = acc & wb_we_i;
  assign reg_sel = wb_adr_i[3:2];

  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);
  assign clear = wr_acc && (reg_sel == 2'd2) && wb_sel_i[0] && wb_dat_i[1];
  assign pop   = rd_acc && (reg_sel == 2'd0) && !empty;

  // Round-robin arbiter: on a tie the channel not served last wins
  always_comb begin
    push_ch = 1'b0;
    unique case (cap_valid_q)
      2'b11:   push_ch = ~last_ch2_q;
      2'b10:   push_ch = 1'b1;
      default: push_ch = 1'b0;
    endcase
  end

  // Clear wins over a push on the same edge
  assign push      = (|cap_valid_q) && !full && !clear;
  assign push_word = {push_ch, cap_data_q[push_ch]};
  assign head      = mem[rd_ptr_q];

  assign rdy_vec = {ch2_point_rdy_i, ch1_point_rdy_i};
  assign pt_vec  = {{ch2_point_t_i, ch2_point_v_i}, {ch1_point_t_i, ch1_point_v_i}};

  // Capture stage: a slot accepts a new point if empty or draining now;
  // otherwise the point is dropped. Disabled or clearing ignores pulses.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cap
    assign drain[gi] = push && (push_ch == 1'(gi));
    assign load[gi]  = rdy_vec[gi] && enable_q && !clear &&
                       (!cap_valid_q[gi] || drain[gi]);
    assign drop[gi]  = rdy_vec[gi] && enable_q && !clear &&
                       cap_valid_q[gi] && !drain[gi];
    assign cap_valid_d[gi] = clear     ? 1'b0 :
                             load[gi]  ? 1'b1 :
                             drain[gi] ? 1'b0 : cap_valid_q[gi];
    assign cap_data_d[gi]  = load[gi] ? pt_vec[gi] : cap_data_q[gi];
  end

  assign drop_sum = {1'b0, drop_cnt_q} + 9'(drop[0]) + 9'(drop[1]);

  assign status_word = {drop_cnt_q, 5'b0, ovf_q, full, empty, 7'b0, 9'(level_q)};
  assign ctrl_word   = {16'h0, irq_thr_q, 7'b0, enable_q};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_ch2_d = last_ch2_q;
    enable_d   = enable_q;
    irq_thr_d  = irq_thr_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    ack_d      = acc;
    dat_d      = dat_q;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      last_ch2_d = push_ch;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    end
    level_d = level_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};

    if (drop != 2'b00) begin
      ovf_d      = 1'b1;
      drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    if (rd_acc) begin
      unique case (reg_sel)
        2'd0:    dat_d = empty ? 32'h0 :
                         {1'b1, head[EW-1], 4'b0, head[PW-1:0]};
        2'd1:    dat_d = status_word;
        2'd2:    dat_d = ctrl_word;
        default: dat_d = 32'h0;
      endcase
    end else if (wr_acc) begin
      dat_d = 32'h0;
      if (reg_sel == 2'd2) begin
        if (wb_sel_i[0]) enable_d  = wb_dat_i[0];
        if (wb_sel_i[1]) irq_thr_d = wb_dat_i[15:8];
      end
    end

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      ovf_d      = 1'b0;
      drop_cnt_d = 8'h0;
    end

    // Interrupt follows the level it will have after this edge
    irq_d = (irq_thr_d != 8'h0) && (9'(level_d) >= {1'b0, irq_thr_d});
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cap_valid_q <= 2'b00;
      cap_data_q  <= '0;
      last_ch2_q  <= 1'b1;
      enable_q    <= 1'b1;
      irq_thr_q   <= 8'h0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= 8'h0;
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      irq_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      last_ch2_q  <= last_ch2_d;
      enable_q    <= enable_d;
      irq_thr_q   <= irq_thr_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      irq_q       <= irq_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_point_fifo_wb.sv
// Testbench for point_fifo_wb: directed scenarios with fixed expected values,
// then a randomized run compared against a queue-based reference model.
module tb_point_fifo_wb;

  localparam int DEPTH = 16;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_adr_i = '0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic        ch1_point_rdy_i = 1'b0;
  logic        ch2_point_rdy_i = 1'b0;
  logic [15:0] ch1_point_v_i = '0;
  logic [15:0] ch2_point_v_i = '0;
  logic [9:0]  ch1_point_t_i = '0;
  logic [9:0]  ch2_point_t_i = '0;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  point_fifo_wb #(.DEPTH_LOG2(4), .V_WIDTH(16), .T_WIDTH(10)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_adr_i(wb_adr_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .ch1_point_rdy_i(ch1_point_rdy_i), .ch2_point_rdy_i(ch2_point_rdy_i),
    .ch1_point_v_i(ch1_point_v_i), .ch2_point_v_i(ch2_point_v_i),
    .ch1_point_t_i(ch1_point_t_i), .ch2_point_t_i(ch2_point_t_i),
    .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- reference model ----------------
  logic [31:0] q[$];
  logic        pend_v[2];
  logic [31:0] pend_w[2];
  logic        m_last;   // 1 = ch2 served last
  logic        m_en;
  logic [7:0]  m_thr;
  logic        m_ovf;
  logic [7:0]  m_drop;
  logic        m_ack;
  logic [31:0] m_dat;
  logic        m_irq;

  task automatic model_reset();
    q.delete();
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    pend_w[0] = '0;   pend_w[1] = '0;
    m_last = 1'b1; m_en = 1'b1; m_thr = 8'h0; m_ovf = 1'b0; m_drop = 8'h0;
    m_ack = 1'b0; m_dat = 32'h0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic        acc, clr, push, pch, full_pre, en_pre;
    logic [1:0]  a;
    int unsigned sz;
    logic        rdy[2];
    logic [15:0] vv[2];
    logic [9:0]  tt[2];
    rdy[0] = ch1_point_rdy_i; rdy[1] = ch2_point_rdy_i;
    vv[0] = ch1_point_v_i;    vv[1] = ch2_point_v_i;
    tt[0] = ch1_point_t_i;    tt[1] = ch2_point_t_i;
    acc = wb_cyc_i && wb_stb_i && !m_ack;
    a = wb_adr_i[3:2];
    sz = q.size();
    full_pre = (sz == DEPTH);
    en_pre = m_en;
    clr = 1'b0;
    push = pend_v[0] || pend_v[1];
    pch = (pend_v[0] && pend_v[1]) ? !m_last : pend_v[1] && !pend_v[0];
    if (full_pre) push = 1'b0;
    if (acc) begin
      if (!wb_we_i) begin
        case (a)
          2'd0: m_dat = (sz > 0) ? q.pop_front() : 32'h0;
          2'd1: m_dat = {m_drop, 5'b0, m_ovf, full_pre, sz == 0, 7'b0, 9'(sz)};
          2'd2: m_dat = {16'h0, m_thr, 7'b0, m_en};
          default: m_dat = 32'h0;
        endcase
      end else begin
        m_dat = 32'h0;
        if (a == 2'd2) begin
          if (wb_sel_i[0]) begin m_en = wb_dat_i[0]; clr = wb_dat_i[1]; end
          if (wb_sel_i[1]) m_thr = wb_dat_i[15:8];
        end
      end
    end
    if (clr) push = 1'b0;
    if (push) begin
      q.push_back(pend_w[pch]);
      pend_v[pch] = 1'b0;
      m_last = pch;
    end
    if (clr) begin
      q.delete();
      pend_v[0] = 1'b0; pend_v[1] = 1'b0;
      m_ovf = 1'b0; m_drop = 8'h0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (en_pre && rdy[ch]) begin
          if (pend_v[ch]) begin
            m_ovf = 1'b1;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'h1;
          end else begin
            pend_v[ch] = 1'b1;
            pend_w[ch] = {1'b1, ch[0], 4'b0, tt[ch], vv[ch]};
          end
        end
      end
    end
    m_ack = acc;
    m_irq = (m_thr != 0) && (q.size() >= m_thr);
  endtask

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) model_reset();
    else          model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic wb_access(input logic we, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic ak);
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = {28'h0, a, 2'b00}; wb_dat_i = d; wb_sel_i = s;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    rd = wb_dat_o; ak = wb_ack_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic pulse(input logic c1, input logic c2,
                       input logic [15:0] v1, input logic [9:0] t1,
                       input logic [15:0] v2, input logic [9:0] t2);
    @(negedge wb_clk_i);
    ch1_point_rdy_i = c1; ch1_point_v_i = v1; ch1_point_t_i = t1;
    ch2_point_rdy_i = c2; ch2_point_v_i = v2; ch2_point_t_i = t2;
    @(negedge wb_clk_i);
    ch1_point_rdy_i = 1'b0; ch2_point_rdy_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd; logic ak;
    wb_rst_i = 1'b1;
    idle(3);
    checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b dat=%h irq=%b expected 0/00000000/0",
               wb_ack_o, wb_dat_o, irq_o);
    end
    wb_rst_i = 1'b0;
    idle(1);
    wb_access(1'b0, 2'd1, 32'h0, 4'h0, rd, ak);
    checks++;
    if (ak !== 1'b1 || rd !== 32'h0001_0000) begin
      errors++;
      $display("FAIL reset_status ack=%b got %h expected 00010000", ak, rd);
    end
    wb_access(1'b0, 2'd2, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++;
      $display("FAIL reset_ctrl got %h expected 00000001", rd);
    end
    // held strobe: ack high for exactly one cycle, then low
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h4;
    @(negedge wb_clk_i);
    checks++;
    if (wb_ack_o !== 1'b1) begin
      errors++; $display("FAIL held_ack_first got %b expected 1", wb_ack_o);
    end
    @(negedge wb_clk_i);
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL held_ack_second got %b expected 0", wb_ack_o);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    idle(2);
    $display("test_reset done");
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd; logic ak;
    pulse(1'b1, 1'b1, 16'h0001, 10'h001, 16'h0002, 10'h002);
    idle(2);
    wb_access(1'b0, 2'd0, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'h8001_0001) begin
      errors++; $display("FAIL simul_first got %h expected 80010001", rd);
    end
    wb_access(1'b0, 2'd0, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'hC002_0002) begin
      errors++; $display("FAIL simul_second got %h expected c0020002", rd);
    end
    wb_access(1'b0, 2'd1, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'h0001_0000) begin
      errors++; $display("FAIL simul_status got %h expected 00010000", rd);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_single_point();
    logic [31:0] rd; logic ak;
    pulse(1'b1, 1'b0, 16'h1234, 10'h2A5, 16'h0, 10'h0);
    wb_access(1'b0, 2'd1, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++; $display("FAIL single_level got %h expected 00000001", rd);
    end
    wb_access(1'b0, 2'd0, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'h82A5_1234) begin
      errors++; $display("FAIL single_data got %h expected 82a51234", rd);
    end
    wb_access(1'b0, 2'd0, 32'h0, 4'h0, rd, ak);
    checks++;
    if (ak !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL empty_read ack=%b got %h expected 00000000", ak, rd);
    end
    wb_access(1'b0, 2'd1, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'h0001_0000) begin
      errors++; $display("FAIL single_after got %h expected 00010000", rd);
    end
    $display("test_single_point done");
  endtask

  task automatic test_full_fifo();
    logic [31:0] rd; logic ak;
    wb_access(1'b1, 2'd2, 32'h0000_0003, 4'b0001, rd, ak);
    for (int i = 0; i < DEPTH; i++) begin
      pulse(1'b1, 1'b0, 16'h0100 + 16'(i), 10'(i), 16'h0, 10'h0);
      idle(1);
    end
    pulse(1'b1, 1'b0, 16'hAAAA, 10'h0AA, 16'h0, 10'h0);
    idle(1);
    pulse(1'b1, 1'b0, 16'hBBBB, 10'h0BB, 16'h0, 10'h0);
    idle(2);
    wb_access(1'b0, 2'd1, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'h0106_0010) begin
      errors++; $display("FAIL full_status got %h expected 01060010", rd);
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [31:0] exp;
      exp = (i < DEPTH) ? {6'b100000, 10'(i), 16'h0100 + 16'(i)} : 32'h80AA_AAAA;
      wb_access(1'b0, 2'd0, 32'h0, 4'h0, rd, ak);
      checks++;
      if (rd !== exp) begin
        errors++; $display("FAIL full_drain_%0d got %h expected %h", i, rd, exp);
      end
      if (i == 0) begin
        idle(1);
        wb_access(1'b0, 2'd1, 32'h0, 4'h0, rd, ak);
        checks++;
        if (rd !== 32'h0106_0010) begin
          errors++; $display("FAIL refill_status got %h expected 01060010", rd);
        end
      end
    end
    $display("test_full_fifo done");
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic ak;
    wb_access(1'b1, 2'd2, 32'h0000_0403, 4'b0011, rd, ak);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1, 16'h0, 10'h0, 16'h5000 + 16'(i), 10'h3FF);
      idle(1);
    end
    idle(1);
    checks++;
    if (irq_o !== 1'b0) begin
      errors++; $display("FAIL irq_below_thr got %b expected 0", irq_o);
    end
    pulse(1'b0, 1'b1, 16'h0, 10'h0, 16'h5003, 10'h3FF);
    idle(1);
    checks++;
    if (irq_o !== 1'b1) begin
      errors++; $display("FAIL irq_at_thr got %b expected 1", irq_o);
    end
    wb_access(1'b0, 2'd2, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'h0000_0401) begin
      errors++; $display("FAIL ctrl_readback got %h expected 00000401", rd);
    end
    wb_access(1'b0, 2'd0, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'hC3FF_5000 || irq_o !== 1'b0) begin
      errors++; $display("FAIL irq_after_pop data=%h irq=%b expected c3ff5000/0", rd, irq_o);
    end
    $display("test_byte_lanes done");
  endtask

  task automatic test_disable();
    logic [31:0] rd; logic ak;
    wb_access(1'b1, 2'd2, 32'h0000_0002, 4'b1111, rd, ak);
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b1, 16'(i), 10'(i), 16'(i), 10'(i));
    idle(2);
    wb_access(1'b0, 2'd1, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'h0001_0000) begin
      errors++; $display("FAIL disable_status got %h expected 00010000", rd);
    end
    wb_access(1'b1, 2'd2, 32'h0000_0001, 4'b1111, rd, ak);
    $display("test_disable done");
  endtask

  task automatic test_random();
    logic active, is_rd;
    logic [31:0] wd;
    int r;
    active = 1'b0; is_rd = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge wb_clk_i);
      checks++;
      if (wb_ack_o !== m_ack) begin
        errors++; $display("FAIL rand_ack cycle %0d got %b expected %b", c, wb_ack_o, m_ack);
      end
      checks++;
      if (irq_o !== m_irq) begin
        errors++; $display("FAIL rand_irq cycle %0d got %b expected %b", c, irq_o, m_irq);
      end
      if (active && wb_ack_o) begin
        if (is_rd) begin
          checks++;
          if (wb_dat_o !== m_dat) begin
            errors++;
            $display("FAIL rand_read cycle %0d adr=%0d got %h expected %h",
                     c, wb_adr_i[3:2], wb_dat_o, m_dat);
          end
        end
        active = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      end else if (!active && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 39);
        active = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        if (r < 38) begin
          is_rd = 1'b1; wb_we_i = 1'b0;
          wb_adr_i = (r < 24) ? 32'h0 : (r < 32) ? 32'h4 : (r < 36) ? 32'h8 : 32'hC;
        end else begin
          is_rd = 1'b0; wb_we_i = 1'b1; wb_adr_i = 32'h8;
          wd = {16'h0, 8'($urandom_range(0, DEPTH + 1)), 6'b0,
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) != 0)};
          wb_dat_i = wd;
          wb_sel_i = 4'($urandom_range(0, 15));
        end
      end
      ch1_point_rdy_i = ($urandom_range(0, 2) == 0);
      ch2_point_rdy_i = ($urandom_range(0, 2) == 0);
      ch1_point_v_i = 16'($urandom); ch1_point_t_i = 10'($urandom);
      ch2_point_v_i = 16'($urandom); ch2_point_t_i = 10'($urandom);
    end
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    ch1_point_rdy_i = 1'b0; ch2_point_rdy_i = 1'b0;
    idle(2);
    $display("test_random done");
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rd; logic ak;
    wb_access(1'b1, 2'd2, 32'h0000_0001, 4'b0001, rd, ak);
    pulse(1'b1, 1'b0, 16'h7777, 10'h077, 16'h0, 10'h0);
    idle(2);
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
    #2 wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL midread_ack got %b expected 0", wb_ack_o);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL midread_ack_after got %b expected 0", wb_ack_o);
    end
    wb_access(1'b0, 2'd1, 32'h0, 4'h0, rd, ak);
    checks++;
    if (rd !== 32'h0001_0000) begin
      errors++; $display("FAIL midread_status got %h expected 00010000", rd);
    end
    $display("test_reset_mid_read done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_simultaneous();
    test_single_point();
    test_full_fifo();
    test_byte_lanes();
    test_disable();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
